// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit path:
// packet codes, PID bytes, encoder states, CRC16 parameters and line encodings.
package usb_pkg;

   typedef enum logic [2:0] {
      PKT_DATA0 = 3'd1,
      PKT_DATA1 = 3'd2,
      PKT_ACK   = 3'd3,
      PKT_NAK   = 3'd4,
      PKT_STALL = 3'd5
   } tx_packet_t;

   localparam logic [7:0] SYNC_BYTE = 8'h80;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_EOP_SE0, ST_EOP_J
   } enc_state_t;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // Line encodings as {dplus, dminus}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   function automatic logic [7:0] pid_byte(input logic [2:0] pkt);
      case (pkt)
         3'd1:    return PID_DATA0;
         3'd2:    return PID_DATA1;
         3'd3:    return PID_ACK;
         3'd4:    return PID_NAK;
         default: return PID_STALL;
      endcase
   endfunction

   function automatic logic [15:0] reflect16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

endpackage

// File: rtl/usb_tx_encoder_if.sv
// Request/line bundle between the buffer-side controller (master) and the encoder (slave).
interface usb_tx_encoder_if;
   logic       tx_start;
   logic [2:0] tx_packet;
   logic [6:0] buffer_occupancy;
   logic [7:0] tx_packet_data;
   logic       get_tx_packet_data;
   logic       tx_transfer_active;
   logic       tx_done;
   logic       dplus_out;
   logic       dminus_out;

   modport master (
      output tx_start, tx_packet, buffer_occupancy, tx_packet_data,
      input  get_tx_packet_data, tx_transfer_active, tx_done, dplus_out, dminus_out
   );

   modport slave (
      input  tx_start, tx_packet, buffer_occupancy, tx_packet_data,
      output get_tx_packet_data, tx_transfer_active, tx_done, dplus_out, dminus_out
   );
endinterface

// File: rtl/usb_crc16.sv
// Serial USB CRC16, fed LSB-first; kept in reflected form so the low byte
// leaves first with its LSB first.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [15:0] o_crc
);
   localparam logic [15:0] POLY_R = reflect16(CRC16_POLY);

   logic [15:0] r_crc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_crc <= CRC16_INIT;
      else if (i_clr) r_crc <= CRC16_INIT;
      else if (i_en)  r_crc <= {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ i_bit) ? POLY_R : 16'h0000);
   end

   assign o_crc = r_crc;
endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed packet serializer: SYNC/PID/payload/CRC16 framing,
// bit stuffing, NRZI and EOP, pulling payload from a show-ahead buffer.
module usb_tx_encoder
   import usb_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int MAX_PAYLOAD  = 64
)(
   input logic            clk,
   input logic            rst,
   usb_tx_encoder_if.slave bus
);
   localparam int         CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

   enc_state_t    r_state, w_state_nx;
   logic [CW-1:0] r_bit_cnt;
   logic [7:0]    r_shift, w_shift_nx;
   logic [2:0]    r_idx, w_idx_nx;
   logic [6:0]    r_len, w_len_nx, r_byte_cnt, w_byte_cnt_nx;
   logic [2:0]    r_pkt, w_pkt_nx;
   logic [2:0]    r_ones, w_ones_nx;
   logic          r_stuff, w_stuff_nx;
   logic [1:0]    r_line, w_line_nx;
   logic          r_active, w_active_nx, r_done, w_done_nx;
   logic          w_bit_end, w_start, w_pop, w_crc_clr, w_crc_en, w_crc_bit;
   logic [15:0]   w_crc;

   function automatic logic [1:0] nrzi_toggle(input logic [1:0] l);
      return {l[0], l[1]};
   endfunction

   usb_crc16 u_crc (
      .clk(clk), .rst(rst), .i_clr(w_crc_clr), .i_en(w_crc_en), .i_bit(w_crc_bit), .o_crc(w_crc)
   );

   assign w_bit_end = (r_state != ST_IDLE) && (r_bit_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_start   = (r_state == ST_IDLE) && bus.tx_start && (bus.tx_packet inside {[3'd1:3'd5]});

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_bit_cnt <= '0;
      else if (r_state == ST_IDLE || w_bit_end) r_bit_cnt <= '0;
      else                                    r_bit_cnt <= r_bit_cnt + 1'b1;
   end

   always_comb begin
      w_state_nx    = r_state;
      w_shift_nx    = r_shift;
      w_idx_nx      = r_idx;
      w_len_nx      = r_len;
      w_byte_cnt_nx = r_byte_cnt;
      w_pkt_nx      = r_pkt;
      w_ones_nx     = r_ones;
      w_stuff_nx    = r_stuff;
      w_line_nx     = r_line;
      w_active_nx   = r_active;
      w_done_nx     = 1'b0;
      w_pop         = 1'b0;
      w_crc_clr     = 1'b0;
      w_crc_en      = 1'b0;
      w_crc_bit     = 1'b0;
      if (w_start) begin
         w_state_nx    = ST_SYNC;
         w_shift_nx    = SYNC_BYTE;
         w_idx_nx      = 3'd0;
         w_len_nx      = (bus.buffer_occupancy > MAX_LEN) ? MAX_LEN : bus.buffer_occupancy;
         w_byte_cnt_nx = 7'd0;
         w_pkt_nx      = bus.tx_packet;
         w_ones_nx     = 3'd0;
         w_stuff_nx    = 1'b0;
         w_line_nx     = nrzi_toggle(r_line);  // SYNC starts with a 0
         w_active_nx   = 1'b1;
         w_crc_clr     = 1'b1;
      end else if (w_bit_end) begin
         case (r_state)
            ST_IDLE: ;
            ST_EOP_SE0: begin
               if (r_idx == 3'd0) w_idx_nx = 3'd1;
               else begin
                  w_state_nx = ST_EOP_J;
                  w_line_nx  = LINE_J;
               end
            end
            ST_EOP_J: begin
               w_state_nx  = ST_IDLE;
               w_active_nx = 1'b0;
               w_done_nx   = 1'b1;
            end
            default: begin
               if (!r_stuff && r_shift[0] && (r_ones == 3'd5)) begin
                  // sixth consecutive 1 just ended: insert a 0 without advancing
                  w_stuff_nx = 1'b1;
                  w_ones_nx  = 3'd0;
                  w_line_nx  = nrzi_toggle(r_line);
               end else begin
                  w_stuff_nx = 1'b0;
                  w_ones_nx  = (!r_stuff && r_shift[0]) ? r_ones + 3'd1 : 3'd0;
                  if (r_idx != 3'd7) begin
                     w_idx_nx   = r_idx + 3'd1;
                     w_shift_nx = {1'b0, r_shift[7:1]};
                     w_crc_en   = (r_state == ST_DATA);
                     w_crc_bit  = r_shift[1];
                  end else begin
                     w_idx_nx = 3'd0;
                     case (r_state)
                        ST_SYNC: begin
                           w_state_nx = ST_PID;
                           w_shift_nx = pid_byte(r_pkt);
                        end
                        ST_PID, ST_DATA: begin
                           if (r_pkt >= PKT_ACK) w_state_nx = ST_EOP_SE0;
                           else if (r_byte_cnt == r_len) begin
                              w_state_nx = ST_CRC_LO;
                              w_shift_nx = ~w_crc[7:0];
                           end else begin
                              w_state_nx    = ST_DATA;
                              w_shift_nx    = bus.tx_packet_data;
                              w_byte_cnt_nx = r_byte_cnt + 7'd1;
                              w_pop         = 1'b1;
                              w_crc_en      = 1'b1;
                              w_crc_bit     = bus.tx_packet_data[0];
                           end
                        end
                        ST_CRC_LO: begin
                           w_state_nx = ST_CRC_HI;
                           w_shift_nx = ~w_crc[15:8];
                        end
                        default: w_state_nx = ST_EOP_SE0;
                     endcase
                  end
                  w_line_nx = (w_state_nx == ST_EOP_SE0) ? LINE_SE0 :
                              w_shift_nx[0] ? r_line : nrzi_toggle(r_line);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_idx      <= '0;
         r_len      <= '0;
         r_byte_cnt <= '0;
         r_pkt      <= '0;
         r_ones     <= '0;
         r_stuff    <= 1'b0;
         r_line     <= LINE_J;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_shift    <= w_shift_nx;
         r_idx      <= w_idx_nx;
         r_len      <= w_len_nx;
         r_byte_cnt <= w_byte_cnt_nx;
         r_pkt      <= w_pkt_nx;
         r_ones     <= w_ones_nx;
         r_stuff    <= w_stuff_nx;
         r_line     <= w_line_nx;
         r_active   <= w_active_nx;
         r_done     <= w_done_nx;
      end
   end

   assign bus.dplus_out          = r_line[1];
   assign bus.dminus_out         = r_line[0];
   assign bus.tx_transfer_active = r_active;
   assign bus.tx_done            = r_done;
   assign bus.get_tx_packet_data = w_pop;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: table-driven and random packets compared symbol by
// symbol against a bit-stream model, plus reset / ignored-request sequences.
module tb_usb_tx_encoder;
   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;

   usb_tx_encoder_if bus();

   usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   // show-ahead buffer model
   logic [7:0] buf_q[$];
   logic       pop_pend = 1'b0;

   always @(negedge clk) pop_pend <= bus.get_tx_packet_data;

   always @(posedge clk) begin
      #1;
      if (pop_pend && buf_q.size() > 0) void'(buf_q.pop_front());
      bus.tx_packet_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
   end

   logic [7:0] pl_q[$];
   logic [1:0] exp_q[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Expected line symbols ({dp,dm}, one per bit time) from the packet rules
   function automatic void build_exp(input logic [2:0] pkt, input int len);
      bit          b[$];
      bit          raw[$];
      logic [3:0]  p4;
      logic [7:0]  pid;
      logic [15:0] crc;
      logic [1:0]  lvl;
      bit          d;
      int          ones;
      case (pkt)
         3'd1:    p4 = 4'h3;
         3'd2:    p4 = 4'hB;
         3'd3:    p4 = 4'h2;
         3'd4:    p4 = 4'hA;
         default: p4 = 4'hE;
      endcase
      pid = {~p4, p4};
      for (int i = 0; i < 8; i++) b.push_back(i == 7);
      for (int i = 0; i < 8; i++) b.push_back(pid[i]);
      if (pkt <= 3'd2) begin
         crc = 16'hFFFF;
         for (int k = 0; k < len; k++)
            for (int i = 0; i < 8; i++) begin
               d = pl_q[k][i];
               b.push_back(d);
               crc = (crc[15] ^ d) ? ((crc << 1) ^ 16'h8005) : (crc << 1);
            end
         for (int i = 15; i >= 0; i--) b.push_back(~crc[i]);
      end
      ones = 0;
      foreach (b[i]) begin
         raw.push_back(b[i]);
         if (b[i]) begin
            ones++;
            if (ones == 6) begin
               raw.push_back(1'b0);
               ones = 0;
            end
         end else ones = 0;
      end
      exp_q.delete();
      lvl = 2'b10;
      foreach (raw[i]) begin
         if (!raw[i]) lvl = {lvl[0], lvl[1]};
         exp_q.push_back(lvl);
      end
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
   endfunction

   task automatic fill(input int occ, input int mode);
      buf_q.delete();
      for (int i = 0; i < occ; i++)
         case (mode)
            0:       buf_q.push_back(8'(i));
            1:       buf_q.push_back(8'hFF);
            default: buf_q.push_back(8'($urandom));
         endcase
   endtask

   task automatic run_pkt(input string nm, input logic [2:0] pkt, input int occ,
                          input int exp_clks, input int inj);
      int len, cyc, first, act_n, bad, pops, dones, sym_i, jbad;
      bit fin;
      len = (pkt <= 3'd2) ? ((occ > 64) ? 64 : occ) : 0;
      pl_q.delete();
      for (int i = 0; i < len; i++) pl_q.push_back(buf_q[i]);
      build_exp(pkt, len);
      @(negedge clk);
      bus.buffer_occupancy = 7'(occ);
      bus.tx_packet        = pkt;
      bus.tx_start         = 1'b1;
      cyc = 0; first = -1; act_n = 0; bad = -1; pops = 0; dones = 0; sym_i = 0; fin = 0;
      while (!fin && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         bus.tx_start = (inj > 0 && cyc == inj);
         if (bus.tx_start) bus.tx_packet = 3'd3;
         if (bus.get_tx_packet_data) pops++;
         if (bus.tx_done) dones++;
         if (bus.tx_transfer_active) begin
            if (first < 0) first = cyc;
            act_n++;
            if (bad < 0 && (sym_i / CPB >= exp_q.size() ||
                            {bus.dplus_out, bus.dminus_out} !== exp_q[sym_i / CPB]))
               bad = sym_i;
            sym_i++;
         end else if (first >= 0) fin = 1;
      end
      chk({nm, "_timeout"}, int'(fin), 1);
      chk({nm, "_done_at_fall"}, int'(bus.tx_done), 1);
      jbad = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.tx_done) dones++;
         if ({bus.dplus_out, bus.dminus_out} !== 2'b10) jbad++;
      end
      chk({nm, "_latency"}, first, 1);
      chk({nm, "_active_clks"}, act_n, (exp_clks > 0) ? exp_clks : exp_q.size() * CPB);
      chk({nm, "_line_first_bad_clk"}, bad, -1);
      chk({nm, "_pops"}, pops, len);
      chk({nm, "_done_pulses"}, dones, 1);
      chk({nm, "_idle_J"}, jbad, 0);
      chk({nm, "_leftover"}, buf_q.size(), occ - len);
      buf_q.delete();
   endtask

   typedef struct {
      string      nm;
      logic [2:0] pkt;
      int         occ;
      int         mode;      // 0 ramp, 1 all 0xFF, 2 random
      int         exp_clks;  // 0: take from model
      int         inj;       // cycle of a stray tx_start, 0 for none
   } vec_t;

   vec_t vecs[9];

   initial begin
      int cyc, sz, bad, seen;
      logic [2:0] bad_codes[3];
      vecs[0] = '{"ack",       3'd3,  0, 0,  76,   0};
      vecs[1] = '{"nak",       3'd4,  0, 0,  76,   0};
      vecs[2] = '{"stall",     3'd5,  0, 0,  76,   0};
      vecs[3] = '{"ack_occ5",  3'd3,  5, 2,  76,   0};
      vecs[4] = '{"data0_zlp", 3'd1,  0, 0, 140,   0};
      vecs[5] = '{"data1_ff",  3'd2,  2, 1,   0,   0};
      vecs[6] = '{"data0_max", 3'd1, 64, 0,   0,   0};
      vecs[7] = '{"data0_inj", 3'd1,  4, 2,   0, 100};
      vecs[8] = '{"data1_clamp", 3'd2, 70, 2,  0,   0};
      bad_codes[0] = 3'd0; bad_codes[1] = 3'd6; bad_codes[2] = 3'd7;

      bus.tx_start = 1'b0;
      bus.tx_packet = 3'd0;
      bus.buffer_occupancy = 7'd0;
      repeat (3) @(negedge clk);
      chk("rst_line", int'({bus.dplus_out, bus.dminus_out}), 2);
      chk("rst_active", int'(bus.tx_transfer_active), 0);
      chk("rst_done", int'(bus.tx_done), 0);
      chk("rst_get", int'(bus.get_tx_packet_data), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_line", int'({bus.dplus_out, bus.dminus_out}), 2);

      foreach (vecs[v]) begin
         fill(vecs[v].occ, vecs[v].mode);
         run_pkt(vecs[v].nm, vecs[v].pkt, vecs[v].occ, vecs[v].exp_clks, vecs[v].inj);
      end

      for (int r = 0; r < 10; r++) begin
         int o;
         logic [2:0] p;
         p = 3'($urandom_range(1, 5));
         o = $urandom_range(0, 20);
         fill(o, 2);
         run_pkt($sformatf("rand%0d", r), p, o, 0, 0);
      end

      // invalid packet codes are ignored
      foreach (bad_codes[i]) begin
         @(negedge clk);
         bus.tx_packet = bad_codes[i];
         bus.tx_start  = 1'b1;
         @(negedge clk);
         bus.tx_start  = 1'b0;
         seen = 0;
         repeat (20) begin
            if (bus.tx_transfer_active) seen++;
            @(negedge clk);
         end
         chk($sformatf("invalid_code%0d", bad_codes[i]), seen, 0);
      end

      // back-to-back: start accepted in the tx_done cycle
      @(negedge clk);
      bus.tx_packet = 3'd3;
      bus.tx_start  = 1'b1;
      @(negedge clk);
      bus.tx_start  = 1'b0;
      cyc = 0;
      while (!bus.tx_done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b_first_len", cyc, 76);
      bus.tx_packet = 3'd4;
      bus.tx_start  = 1'b1;
      @(negedge clk);
      bus.tx_start  = 1'b0;
      chk("b2b_restart_active", int'(bus.tx_transfer_active), 1);
      chk("b2b_first_bit_K", int'({bus.dplus_out, bus.dminus_out}), 1);
      cyc = 0;
      while (!bus.tx_done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b_second_len", cyc, 76);

      // reset in the middle of a DATA packet
      fill(8, 2);
      @(negedge clk);
      bus.buffer_occupancy = 7'd8;
      bus.tx_packet = 3'd1;
      bus.tx_start  = 1'b1;
      @(negedge clk);
      bus.tx_start  = 1'b0;
      repeat (150) @(negedge clk);
      chk("midrst_was_active", int'(bus.tx_transfer_active), 1);
      rst = 1'b1;
      #1;
      sz = buf_q.size();
      chk("midrst_line_J", int'({bus.dplus_out, bus.dminus_out}), 2);
      chk("midrst_active", int'(bus.tx_transfer_active), 0);
      chk("midrst_get", int'(bus.get_tx_packet_data), 0);
      chk("midrst_done", int'(bus.tx_done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (10 * CPB) begin
         @(negedge clk);
         if ({bus.dplus_out, bus.dminus_out} !== 2'b10 || bus.tx_transfer_active ||
             bus.tx_done || bus.get_tx_packet_data) bad++;
      end
      chk("midrst_hold_J", bad, 0);
      chk("midrst_buf_untouched", buf_q.size(), sz);
      buf_q.delete();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
